// File: rtl/shift_reg_ctl_if.sv
// Handshake/data bundle for shift_reg_ctl: command inputs plus registered status.
// The master drives commands and serial input; the slave returns register state.
interface shift_reg_ctl_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic             en;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amt, din, sin, en,
    input  q, sout, busy, done
  );

  modport slave (
    input  start, op, amt, din, sin, en,
    output q, sout, busy, done
  );
endinterface

// File: rtl/shift_reg_ctl.sv
// WIDTH-bit register with load/clear and bit-serial shift/rotate operations,
// one step per enabled cycle, with busy/done handshake.
module shift_reg_ctl #(
  parameter int               WIDTH     = 8,
  parameter int               AMT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  shift_reg_ctl_if.slave bus
);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROTL  = 3'b100,
    OP_ROTR  = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  op_e req_op;
  assign req_op = op_e'(bus.op);

  // Returns {sout, q} after one single-bit step of a multi-step op.
  function automatic logic [WIDTH:0] step(op_e o, logic [WIDTH-1:0] v,
                                          logic s, logic cur_sout);
    case (o)
      OP_SHL:  return {v[WIDTH-1], v[WIDTH-2:0], s};
      OP_SHR:  return {v[0], s, v[WIDTH-1:1]};
      OP_ROTL: return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROTR: return {v[0], v[0], v[WIDTH-1:1]};
      OP_ASR:  return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: return {cur_sout, v};
    endcase
  endfunction

  function automatic logic is_shift(op_e o);
    return (o != OP_HOLD) && (o != OP_LOAD) && (o != OP_CLEAR);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_shift(req_op) && (bus.amt != '0)) begin
            state_d = RUN;
            op_d    = req_op;
            cnt_d   = bus.amt;
          end else begin
            done_d = 1'b1;
            if (req_op == OP_LOAD) begin
              q_d = bus.din;
            end else if (req_op == OP_CLEAR) begin
              q_d    = '0;
              sout_d = 1'b0;
            end
          end
        end
      end
      RUN: begin
        if (bus.en) begin
          {sout_d, q_d} = step(op_q, q_q, bus.sin, sout_q);
          cnt_d         = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset aborts any running op without a done pulse.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
      q_q     <= RESET_VAL;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.sout = sout_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;

endmodule

// File: tb/tb_shift_reg_ctl.sv
// Self-checking bench for shift_reg_ctl: directed table, hand-written corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_shift_reg_ctl;
  localparam int             W    = 8;
  localparam int             AW   = 4;
  localparam logic [W-1:0]   RV   = 8'h00;
  localparam int             MASK = (1 << W) - 1;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         ROTL = 3'b100, ROTR = 3'b101, ASR = 3'b110, CLEAR = 3'b111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_reg_ctl_if #(.WIDTH(W), .AMT_W(AW)) bus();

  shift_reg_ctl #(.WIDTH(W), .AMT_W(AW), .RESET_VAL(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  din;
    logic          sin;
    logic [W-1:0]  exp_q;
    logic          exp_sout;
    int            exp_busy;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [2:0] o, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic s, input logic e);
    bus.start = st;
    bus.op    = o;
    bus.amt   = a;
    bus.din   = d;
    bus.sin   = s;
    bus.en    = e;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    drive(1'b1, v.op, v.amt, v.din, v.sin, 1'b1);
    cycle();
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.amt   = AW'($urandom);
    bus.din   = W'($urandom);
    n = 0;
    while (bus.busy && n < 40) begin
      check($sformatf("vec%0d done_during_busy", idx), bus.done, 0);
      n++;
      cycle();
    end
    check($sformatf("vec%0d busy_cycles", idx), n, v.exp_busy);
    check($sformatf("vec%0d done", idx), bus.done, 1);
    check($sformatf("vec%0d q", idx), bus.q, v.exp_q);
    check($sformatf("vec%0d sout", idx), bus.sout, v.exp_sout);
    cycle();
    check($sformatf("vec%0d done_one_cycle", idx), bus.done, 0);
  endtask

  // Reference model: whole-op semantics with a remaining-step count and
  // integer shift/rotate arithmetic.
  int m_q, m_sout, m_rem, m_done;
  logic [2:0] m_op;

  task automatic model_step(input logic [2:0] o, input int s);
    int v;
    v = m_q;
    case (o)
      SHL:  begin m_sout = (v >> (W-1)) & 1; m_q = ((v << 1) | s) & MASK; end
      SHR:  begin m_sout = v & 1; m_q = (v >> 1) | (s << (W-1)); end
      ROTL: begin m_sout = (v >> (W-1)) & 1; m_q = ((v << 1) | (v >> (W-1))) & MASK; end
      ROTR: begin m_sout = v & 1; m_q = (v >> 1) | ((v & 1) << (W-1)); end
      ASR:  begin m_sout = v & 1; m_q = (v >> 1) | (v & (1 << (W-1))); end
      default: ;
    endcase
  endtask

  task automatic model_edge(input logic r, input logic st, input logic [2:0] o,
                            input int a, input int d, input int s, input logic e);
    if (r) begin
      m_q = int'(RV); m_sout = 0; m_rem = 0; m_done = 0;
    end else if (m_rem > 0) begin
      m_done = 0;
      if (e) begin
        model_step(m_op, s);
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end
    end else begin
      m_done = 0;
      if (st) begin
        if (o inside {SHL, SHR, ROTL, ROTR, ASR} && a > 0) begin
          m_op = o; m_rem = a;
        end else begin
          m_done = 1;
          if (o == LOAD) m_q = d;
          if (o == CLEAR) begin m_q = 0; m_sout = 0; end
        end
      end
    end
  endtask

  initial begin
    int nb, nd;
    logic [7:0] shl_exp[3];

    tbl[0]  = '{LOAD,  4'd0,  8'hA5, 1'b0, 8'hA5, 1'b0, 0};
    tbl[1]  = '{SHL,   4'd3,  8'h00, 1'b1, 8'h2F, 1'b1, 3};
    tbl[2]  = '{ROTR,  4'd8,  8'h00, 1'b0, 8'h2F, 1'b0, 8};
    tbl[3]  = '{LOAD,  4'd0,  8'h96, 1'b0, 8'h96, 1'b0, 0};
    tbl[4]  = '{ASR,   4'd2,  8'h00, 1'b0, 8'hE5, 1'b1, 2};
    tbl[5]  = '{HOLD,  4'd5,  8'h11, 1'b0, 8'hE5, 1'b1, 0};
    tbl[6]  = '{ROTL,  4'd0,  8'h22, 1'b0, 8'hE5, 1'b1, 0};
    tbl[7]  = '{CLEAR, 4'd3,  8'h33, 1'b1, 8'h00, 1'b0, 0};
    tbl[8]  = '{LOAD,  4'd0,  8'h81, 1'b0, 8'h81, 1'b0, 0};
    tbl[9]  = '{ROTL,  4'd10, 8'h00, 1'b0, 8'h06, 1'b0, 10};
    tbl[10] = '{SHR,   4'd3,  8'h00, 1'b0, 8'h00, 1'b1, 3};
    tbl[11] = '{SHL,   4'd9,  8'h00, 1'b1, 8'hFF, 1'b1, 9};
    tbl[12] = '{LOAD,  4'd0,  8'h70, 1'b0, 8'h70, 1'b1, 0};
    tbl[13] = '{ASR,   4'd3,  8'h00, 1'b0, 8'h0E, 1'b0, 3};
    tbl[14] = '{SHR,   4'd2,  8'h00, 1'b1, 8'hC3, 1'b1, 2};

    // Reset held for two cycles while a LOAD is being requested.
    rst = 1'b1;
    drive(1'b1, LOAD, 4'd0, 8'hFF, 1'b0, 1'b1);
    cycle();
    cycle();
    check("reset q", bus.q, RV);
    check("reset sout", bus.sout, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    rst = 1'b0;
    drive(1'b0, HOLD, 4'd0, 8'h00, 1'b0, 1'b1);
    cycle();
    check("idle done", bus.done, 0);

    // LOAD then SHL 3 with a start pulse mid-run.
    drive(1'b1, LOAD, 4'd0, 8'hA5, 1'b0, 1'b1);
    cycle();
    check("load q", bus.q, 8'hA5);
    check("load done", bus.done, 1);
    check("load busy", bus.busy, 0);
    drive(1'b1, SHL, 4'd3, 8'h00, 1'b1, 1'b1);
    cycle();
    check("shl accept busy", bus.busy, 1);
    check("shl accept q", bus.q, 8'hA5);
    check("shl accept done", bus.done, 0);
    shl_exp = '{8'h4B, 8'h97, 8'h2F};
    for (int i = 0; i < 3; i++) begin
      bus.start = (i == 1);
      bus.op    = LOAD;
      cycle();
      bus.start = 1'b0;
      check($sformatf("shl step%0d q", i), bus.q, shl_exp[i]);
      check($sformatf("shl step%0d busy", i), bus.busy, (i < 2) ? 1 : 0);
      check($sformatf("shl step%0d done", i), bus.done, (i == 2) ? 1 : 0);
    end
    check("shl sout", bus.sout, 1);

    // ROTR 8 with two paused cycles mid-run.
    drive(1'b1, ROTR, 4'd8, 8'h00, 1'b0, 1'b1);
    cycle();
    bus.start = 1'b0;
    nb = 0; nd = 0;
    for (int k = 0; k < 16; k++) begin
      bus.en = !(k == 3 || k == 4);
      if (bus.busy) nb++;
      if (bus.done) nd++;
      check("rotr done&busy exclusive", bus.busy & bus.done, 0);
      cycle();
    end
    bus.en = 1'b1;
    check("rotr busy cycles", nb, 10);
    check("rotr done pulses", nd, 1);
    check("rotr q", bus.q, 8'h2F);

    // ASR 2 then LOAD issued in the done cycle.
    drive(1'b1, LOAD, 4'd0, 8'h96, 1'b0, 1'b1);
    cycle();
    drive(1'b1, ASR, 4'd2, 8'h00, 1'b0, 1'b1);
    cycle();
    bus.start = 1'b0;
    cycle();
    check("asr step1 q", bus.q, 8'hCB);
    cycle();
    check("asr step2 q", bus.q, 8'hE5);
    check("asr sout", bus.sout, 1);
    check("asr done", bus.done, 1);
    drive(1'b1, LOAD, 4'd0, 8'h00, 1'b0, 1'b1);
    cycle();
    bus.start = 1'b0;
    check("b2b load q", bus.q, 8'h00);
    check("b2b load done", bus.done, 1);

    // SHR 5 aborted by reset after two steps.
    drive(1'b1, LOAD, 4'd0, 8'hF0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, SHR, 4'd5, 8'h00, 1'b0, 1'b1);
    cycle();
    bus.start = 1'b0;
    cycle();
    cycle();
    check("shr step2 q", bus.q, 8'h3C);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort q", bus.q, RV);
    check("abort busy", bus.busy, 0);
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done || bus.busy) nd++;
      cycle();
    end
    check("abort no done/busy after", nd, 0);

    // Directed table, starting from reset state.
    do_reset();
    for (int i = 0; i < 15; i++) run_vec(tbl[i], i);

    // Randomized traffic against the reference model.
    do_reset();
    m_q = int'(RV); m_sout = 0; m_rem = 0; m_done = 0; m_op = HOLD;
    for (int c = 0; c < 3000; c++) begin
      logic r, st, e, s;
      logic [2:0] o;
      logic [AW-1:0] a;
      logic [W-1:0] d;
      r  = ($urandom_range(0, 249) == 0);
      st = ($urandom_range(0, 2) == 0);
      o  = 3'($urandom);
      a  = AW'($urandom_range(0, 11));
      d  = W'($urandom);
      s  = 1'($urandom);
      e  = ($urandom_range(0, 3) != 0);
      rst = r;
      drive(st, o, a, d, s, e);
      model_edge(r, st, o, int'(a), int'(d), int'(s), e);
      cycle();
      check($sformatf("rand c%0d {q,sout,busy,done}", c),
            {bus.q, bus.sout, bus.busy, bus.done},
            {W'(m_q), 1'(m_sout), (m_rem > 0), 1'(m_done)});
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
